// File: rtl/gppcu_instr_fetch.sv
// gppcu_instr_fetch -- instruction fetch front end for the GPPCU.
//
// Fetches 32-bit instruction words from a synchronous instruction memory
// (data valid one cycle after the read strobe). Each word is presented to
// the decoder with a valid/ready handshake. A word whose opcode equals
// HALT_OPC ends the program and is never presented.
//
// Optional feature (macro GPPCU_FETCH_STEP_EN): single-step mode. FETCH
// holds with no read until an iSTEP pulse arrives. Exactly one instruction
// is fetched per pulse.
//
// Ports:
//   iCLK, iACLR_N          clock (rising edge), async active-low reset
//   iSTART, iBASE          start pulse and program start address (IDLE only)
//   iABORT                 synchronous abort back to IDLE
//   oIMEM_RD, oIMEM_ADDR   instruction-memory read strobe / word address
//   iIMEM_DATA             read data, one cycle after oIMEM_RD
//   oOPC, oOPERAND, oPC    presented instruction fields and its address
//   oVALID, iREADY         presentation handshake
//   oBUSY, oDONE           program in progress / one-cycle completion pulse
//   iSTEP                  single-step pulse (GPPCU_FETCH_STEP_EN only)
module gppcu_instr_fetch #(
  parameter int         ADDR_W   = 10,
  parameter logic [4:0] HALT_OPC = 5'b11111
) (
  input  logic              iCLK,
  input  logic              iACLR_N,
  input  logic              iSTART,
  input  logic [ADDR_W-1:0] iBASE,
  input  logic              iABORT,
  output logic              oIMEM_RD,
  output logic [ADDR_W-1:0] oIMEM_ADDR,
  input  logic [31:0]       iIMEM_DATA,
  output logic [4:0]        oOPC,
  output logic [26:0]       oOPERAND,
  output logic [ADDR_W-1:0] oPC,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oBUSY,
`ifdef GPPCU_FETCH_STEP_EN
  output logic              oDONE,
  input  logic              iSTEP
`else
  output logic              oDONE
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] pc;
  logic              stepGo;
  logic              isHalt;

`ifdef GPPCU_FETCH_STEP_EN
  assign stepGo = iSTEP;
`else
  assign stepGo = 1'b1;
`endif

  assign isHalt     = (iIMEM_DATA[31:27] == HALT_OPC);
  assign oIMEM_ADDR = pc;

  always_ff @(posedge iCLK or negedge iACLR_N) begin
    if (!iACLR_N) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    oIMEM_RD  = 1'b0;
    oBUSY     = 1'b1;
    oDONE     = 1'b0;
    case (state)
      IDLE: begin
        oBUSY = 1'b0;
        // abort wins over a simultaneous start
        if (iSTART && !iABORT) nextState = FETCH;
      end
      FETCH: begin
        if (iABORT) begin
          nextState = IDLE;
        end else if (stepGo) begin
          oIMEM_RD  = 1'b1;
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (iABORT)      nextState = IDLE;
        else if (isHalt) nextState = DONE;
        else             nextState = ISSUE;
      end
      ISSUE: begin
        // abort together with ready still completes the transfer; in both
        // cases the FSM leaves ISSUE and oVALID drops
        if (iABORT)      nextState = IDLE;
        else if (iREADY) nextState = FETCH;
      end
      DONE: begin
        oDONE     = 1'b1;
        nextState = IDLE;
      end
      default: begin
        oBUSY     = 1'b0;
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iACLR_N) begin
    if (!iACLR_N) begin
      pc       <= '0;
      oOPC     <= '0;
      oOPERAND <= '0;
      oPC      <= '0;
      oVALID   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART && !iABORT) pc <= iBASE;
        end
        WAIT: begin
          // an aborted read is dropped without touching the output register
          if (!iABORT) begin
            oOPC     <= iIMEM_DATA[31:27];
            oOPERAND <= iIMEM_DATA[26:0];
            if (!isHalt) begin
              oVALID <= 1'b1;
              oPC    <= pc;
              pc     <= pc + ADDR_W'(1);  // wraps modulo 2^ADDR_W
            end
          end
        end
        ISSUE: begin
          if (iABORT || iREADY) oVALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gppcu_instr_fetch.sv
// Directed bench for gppcu_instr_fetch with a read/issue scoreboard.
// Build with GPPCU_FETCH_STEP_EN defined to also exercise single-step mode.
module tb_gppcu_instr_fetch;
  localparam int         AW   = 10;
  localparam logic [4:0] HALT = 5'b11111;

  logic          iCLK = 1'b0;
  logic          iACLR_N = 1'b0;
  logic          iSTART = 1'b0;
  logic          iABORT = 1'b0;
  logic          iREADY = 1'b1;
  logic          iSTEP = 1'b1;
  logic [AW-1:0] iBASE = '0;
  logic [31:0]   iIMEM_DATA = '0;
  logic          oIMEM_RD, oVALID, oBUSY, oDONE;
  logic [AW-1:0] oIMEM_ADDR, oPC;
  logic [4:0]    oOPC;
  logic [26:0]   oOPERAND;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  int            doneCnt = 0;
  int            d0;
  logic [AW-1:0] rdQ [$];
  logic [41:0]   isQ [$];

  always #5 iCLK = ~iCLK;

  // synchronous instruction memory: data valid one cycle after the strobe
  always @(posedge iCLK) if (oIMEM_RD) iIMEM_DATA <= mem[oIMEM_ADDR];

  gppcu_instr_fetch #(.ADDR_W(AW), .HALT_OPC(HALT)) dut (
    .iCLK(iCLK), .iACLR_N(iACLR_N), .iSTART(iSTART), .iBASE(iBASE),
    .iABORT(iABORT), .oIMEM_RD(oIMEM_RD), .oIMEM_ADDR(oIMEM_ADDR),
    .iIMEM_DATA(iIMEM_DATA), .oOPC(oOPC), .oOPERAND(oOPERAND), .oPC(oPC),
    .oVALID(oVALID), .iREADY(iREADY), .oBUSY(oBUSY),
`ifdef GPPCU_FETCH_STEP_EN
    .oDONE(oDONE), .iSTEP(iSTEP)
`else
    .oDONE(oDONE)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr(input logic [4:0] opc, input logic [26:0] opnd);
    return {opc, opnd};
  endfunction

  function automatic logic [41:0] iss(input logic [AW-1:0] pc, input logic [4:0] opc,
                                      input logic [26:0] opnd);
    return {pc, opc, opnd};
  endfunction

  // scoreboard: every read strobe and every accepted transfer is popped here
  always begin
    @(negedge iCLK);
    #2;
    if (oDONE === 1'b1) doneCnt++;
    if (oIMEM_RD === 1'b1) begin
      if (rdQ.size() == 0) check("rd_unexpected", 64'(oIMEM_ADDR), 64'hDEAD);
      else                 check("rd_addr", 64'(oIMEM_ADDR), 64'(rdQ.pop_front()));
    end
    if (oVALID === 1'b1 && iREADY === 1'b1) begin
      if (isQ.size() == 0) check("issue_unexpected", 64'({oPC, oOPC, oOPERAND}), 64'hDEAD);
      else                 check("issue", 64'({oPC, oOPC, oOPERAND}), 64'(isQ.pop_front()));
    end
  end

  task automatic startProg(input logic [AW-1:0] base);
    iBASE  = base;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic waitIdle(input int maxc);
    int n = 0;
    while (oBUSY === 1'b1 && n < maxc) begin
      @(negedge iCLK);
      n++;
    end
    check("busy_end", 64'(oBUSY), 64'd0);
  endtask

  task automatic waitValid(input int maxc);
    int n = 0;
    while (oVALID !== 1'b1 && n < maxc) begin
      @(negedge iCLK);
      n++;
    end
    check("valid_seen", 64'(oVALID), 64'd1);
  endtask

  task automatic checkDrained(input string tag);
    check({tag, "_rdq"}, 64'(rdQ.size()), 64'd0);
    check({tag, "_isq"}, 64'(isQ.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = instr(HALT, 27'd0);

    // reset state
    repeat (2) @(negedge iCLK);
    check("rst_valid", 64'(oVALID), 64'd0);
    check("rst_busy",  64'(oBUSY),  64'd0);
    check("rst_done",  64'(oDONE),  64'd0);
    check("rst_rd",    64'(oIMEM_RD), 64'd0);
    check("rst_addr",  64'(oIMEM_ADDR), 64'd0);
    check("rst_fields", 64'({oPC, oOPC, oOPERAND}), 64'd0);
    iACLR_N = 1'b1;
    repeat (2) @(negedge iCLK);
    check("idle_wait", 64'(oBUSY), 64'd0);

    // basic program, ready always high
    mem[10'h010] = 32'h0800_0000;
    mem[10'h011] = 32'h1000_0005;
    rdQ.push_back(10'h010); rdQ.push_back(10'h011); rdQ.push_back(10'h012);
    isQ.push_back(iss(10'h010, 5'd1, 27'd0));
    isQ.push_back(iss(10'h011, 5'd2, 27'd5));
    d0 = doneCnt;
    startProg(10'h010);
    check("t1_fetch_rd",   64'(oIMEM_RD), 64'd1);
    check("t1_fetch_busy", 64'(oBUSY), 64'd1);
    waitIdle(50);
    check("t1_done", 64'(doneCnt - d0), 64'd1);
    checkDrained("t1");

    // back-pressure: 5 stalled cycles; a start during the stall is ignored
    mem[10'h040] = instr(5'd3, 27'h123);
    rdQ.push_back(10'h040); rdQ.push_back(10'h041);
    isQ.push_back(iss(10'h040, 5'd3, 27'h123));
    iREADY = 1'b0;
    d0 = doneCnt;
    startProg(10'h040);
    waitValid(20);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 64'(oVALID), 64'd1);
      check("t2_hold_fields", 64'({oPC, oOPC, oOPERAND}), 64'(iss(10'h040, 5'd3, 27'h123)));
      check("t2_hold_rd", 64'(oIMEM_RD), 64'd0);
      iSTART = (i == 1);
      iBASE  = 10'h200;
      @(negedge iCLK);
    end
    iSTART = 1'b0;
    iREADY = 1'b1;
    waitIdle(50);
    check("t2_done", 64'(doneCnt - d0), 64'd1);
    checkDrained("t2");

    // PC wrap from all-ones to zero
    mem[10'h3FF] = instr(5'd4, 27'd1);
    mem[10'h000] = instr(5'd5, 27'd2);
    rdQ.push_back(10'h3FF); rdQ.push_back(10'h000); rdQ.push_back(10'h001);
    isQ.push_back(iss(10'h3FF, 5'd4, 27'd1));
    isQ.push_back(iss(10'h000, 5'd5, 27'd2));
    d0 = doneCnt;
    startProg(10'h3FF);
    waitIdle(50);
    check("t3_done", 64'(doneCnt - d0), 64'd1);
    checkDrained("t3");

    // abort in WAIT, then a fresh start from its own base
    mem[10'h080] = instr(5'd6, 27'd6);
    rdQ.push_back(10'h080);
    d0 = doneCnt;
    startProg(10'h080);       // now in FETCH
    @(negedge iCLK);          // now in WAIT
    iABORT = 1'b1;
    @(negedge iCLK);
    iABORT = 1'b0;
    check("t4_abort_busy",  64'(oBUSY), 64'd0);
    check("t4_abort_valid", 64'(oVALID), 64'd0);
    repeat (3) @(negedge iCLK);
    check("t4_no_valid", 64'(oVALID), 64'd0);
    check("t4_no_done", 64'(doneCnt - d0), 64'd0);
    // abort together with start in IDLE stays idle
    iSTART = 1'b1; iABORT = 1'b1; iBASE = 10'h300;
    @(negedge iCLK);
    iSTART = 1'b0; iABORT = 1'b0;
    check("t4_abort_start", 64'(oBUSY), 64'd0);
    mem[10'h090] = instr(5'd7, 27'd7);
    rdQ.push_back(10'h090); rdQ.push_back(10'h091);
    isQ.push_back(iss(10'h090, 5'd7, 27'd7));
    startProg(10'h090);
    waitIdle(50);
    check("t4_done", 64'(doneCnt - d0), 64'd1);
    checkDrained("t4");

    // asynchronous reset while presenting an instruction
    mem[10'h0A0] = instr(5'd8, 27'd8);
    rdQ.push_back(10'h0A0);
    iREADY = 1'b0;
    startProg(10'h0A0);
    waitValid(20);
    #3 iACLR_N = 1'b0;
    #1;
    check("t5_async_valid", 64'(oVALID), 64'd0);
    check("t5_async_busy",  64'(oBUSY), 64'd0);
    check("t5_async_fields", 64'({oPC, oOPC, oOPERAND}), 64'd0);
    check("t5_async_addr", 64'(oIMEM_ADDR), 64'd0);
    @(negedge iCLK);
    iACLR_N = 1'b1;
    iREADY  = 1'b1;
    repeat (3) @(negedge iCLK);
    check("t5_idle_after", 64'(oBUSY), 64'd0);
    checkDrained("t5");

`ifdef GPPCU_FETCH_STEP_EN
    // single-step: no reads without iSTEP, one issue per pulse
    mem[10'h0C0] = instr(5'd9, 27'd9);
    mem[10'h0C1] = instr(5'd10, 27'd10);
    iSTEP = 1'b0;
    startProg(10'h0C0);
    for (int i = 0; i < 10; i++) begin
      check("t6_no_rd", 64'(oIMEM_RD), 64'd0);
      @(negedge iCLK);
    end
    for (int p = 0; p < 2; p++) begin
      rdQ.push_back(AW'(10'h0C0 + p));
      isQ.push_back(iss(AW'(10'h0C0 + p), 5'(9 + p), 27'(9 + p)));
      iSTEP = 1'b1;
      @(negedge iCLK);
      iSTEP = 1'b0;
      repeat (5) @(negedge iCLK);
    end
    check("t6_busy", 64'(oBUSY), 64'd1);
    checkDrained("t6");
    iABORT = 1'b1;
    @(negedge iCLK);
    iABORT = 1'b0;
    iSTEP  = 1'b1;
    check("t6_abort", 64'(oBUSY), 64'd0);
`endif

    repeat (2) @(negedge iCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gppcu_instr_fetch.md
GPPCU_INSTR_FETCH -- requirements
Module: gppcu_instr_fetch

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL provide parameter HALT_OPC, default 5'b11111, opcode that ends a program and is never issued.
REQ-003 SHALL have ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iACLR_N  in  1  asynchronous active-low reset.
- iSTART  in  1  one-cycle pulse that starts a program.
- iBASE  in  ADDR_W  start address, sampled with iSTART.
- iABORT  in  1  synchronous abort.
- oIMEM_RD  out  1  instruction-memory read strobe.
- oIMEM_ADDR  out  ADDR_W  read address.
- iIMEM_DATA  in  32  read data, valid exactly one cycle after oIMEM_RD.
- oOPC  out  5  opcode to the decoder, instruction bits [31:27].
- oOPERAND  out  27  instruction bits [26:0].
- oPC  out  ADDR_W  address of the presented instruction.
- oVALID  out  1  presented instruction valid.
- iREADY  in  1  downstream accepts.
- oBUSY  out  1  program in progress.
- oDONE  out  1  one-cycle completion pulse.
- iSTEP  in  1  single-step pulse; present only with GPPCU_FETCH_STEP_EN.
REQ-004 SHALL have one clock, iCLK, and an asynchronous active-low reset, iACLR_N; no other clock or reset.

Function
REQ-005 SHALL implement the FSM states IDLE, FETCH, WAIT, ISSUE and DONE.
REQ-006 IDLE SHALL hold oBUSY=0; on iSTART it SHALL load PC<=iBASE and go to FETCH.
REQ-007 iSTART outside IDLE SHALL be ignored.
REQ-008 FETCH SHALL assert oIMEM_RD=1 with oIMEM_ADDR=PC for exactly one cycle, then go to WAIT.
REQ-009 WAIT SHALL register iIMEM_DATA into the output register. If bits [31:27]==HALT_OPC it SHALL go to DONE with oVALID kept 0. Otherwise it SHALL set oVALID=1, oPC=PC and PC<=PC+1, and go to ISSUE.
REQ-010 In ISSUE, oOPC, oOPERAND and oPC SHALL stay stable while oVALID=1 and iREADY=0.
REQ-011 In ISSUE, oVALID&&iREADY SHALL complete the transfer: oVALID<=0 and go to FETCH.
REQ-012 Minimum issue interval SHALL be 3 cycles per instruction (FETCH, WAIT, ISSUE with iREADY=1).
REQ-013 DONE SHALL assert oDONE=1 for one cycle, then go to IDLE.
REQ-014 oBUSY SHALL be 1 in FETCH, WAIT, ISSUE and DONE.
REQ-015 PC SHALL increment modulo 2^ADDR_W, wrapping from all-ones to 0 without error.
REQ-016 iABORT in any non-IDLE state SHALL force IDLE on the next edge with oVALID<=0, oIMEM_RD<=0 and no oDONE; an in-flight read SHALL be discarded.
REQ-017 If iABORT and iREADY are both high in ISSUE with oVALID=1, the transfer SHALL count as completed and the state SHALL go to IDLE.
REQ-018 iABORT in IDLE SHALL have no effect; iABORT together with iSTART in IDLE SHALL leave the block in IDLE.
REQ-019 oIMEM_RD SHALL be 0 in every state except FETCH.

Reset
REQ-020 iACLR_N=0 SHALL immediately force state=IDLE and set all outputs and internal registers to 0: oVALID, oBUSY, oDONE, oIMEM_RD, oIMEM_ADDR, oOPC, oOPERAND, oPC and PC.
REQ-021 After iACLR_N deasserts, the block SHALL wait in IDLE for iSTART.
REQ-022 Reset during ISSUE SHALL drop oVALID asynchronously.

Configuration
REQ-023 With GPPCU_FETCH_STEP_EN defined, port iSTEP SHALL exist, and FETCH SHALL hold with oIMEM_RD=0 until an iSTEP pulse; only then it SHALL assert the read. One instruction SHALL be issued per iSTEP pulse, and iABORT SHALL still apply.
REQ-024 With GPPCU_FETCH_STEP_EN undefined, iSTEP SHALL be absent and fetch SHALL be free-running as in REQ-008.

Verification
REQ-025 Reset, then iSTART with iBASE=0x010; memory holds 0x08000000 (opcode 1), 0x10000005 (opcode 2), then HALT_OPC; iREADY=1 -> reads at 0x010, 0x011 and 0x012; oOPC=1 then 2; oDONE pulses once; oBUSY returns to 0.
REQ-026 iREADY held 0 for 5 cycles in ISSUE -> oVALID, oOPC and oPC stable for all 5 cycles; no oIMEM_RD until iREADY=1.
REQ-027 iBASE=all-ones (0x3FF), 2 instructions then HALT -> second read at address 0x000, HALT read at 0x001.
REQ-028 iABORT asserted in WAIT -> IDLE next cycle, oVALID=0, oDONE=0; a new iSTART then fetches from its own iBASE.
REQ-029 iACLR_N pulled low in ISSUE -> oVALID=0 and oBUSY=0 immediately, without waiting for a clock edge.
REQ-030 With GPPCU_FETCH_STEP_EN: iSTART, then no iSTEP for 10 cycles -> oIMEM_RD=0 throughout; 2 iSTEP pulses -> exactly 2 reads and 2 issues.
